// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned ROWS           = 4;
   localparam int unsigned COLS           = 4;
   localparam int unsigned IDX_W          = 2;
   localparam int unsigned CODE_W         = 4;
   localparam int unsigned CNT_W          = 8;
   localparam int unsigned SCAN_DWELL_MIN = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_e;

   // Result of decoding one row sample.
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } row_hit_t;

   // Key code indexed by {row, column}.
   localparam logic [CODE_W-1:0] KEY_CODE [ROWS*COLS] = '{
      4'hf, 4'he, 4'hd, 4'hc,
      4'hb, 4'h3, 4'h6, 4'h9,
      4'ha, 4'h2, 4'h5, 4'h8,
      4'h0, 4'h1, 4'h4, 4'h7
   };

   // Exactly one active-low row bit is a valid key; anything else is rejected.
   function automatic row_hit_t one_low(input logic [ROWS-1:0] row);
      row_hit_t h;
      h = '0;
      case (row)
         4'b1110: begin h.valid = 1'b1; h.idx = 2'd0; end
         4'b1101: begin h.valid = 1'b1; h.idx = 2'd1; end
         4'b1011: begin h.valid = 1'b1; h.idx = 2'd2; end
         4'b0111: begin h.valid = 1'b1; h.idx = 2'd3; end
         default: h = '0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
module row_sync
   import keypad_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [ROWS-1:0] d_i,
   output logic [ROWS-1:0] q_o
);

   logic [ROWS-1:0] meta_q;
   logic [ROWS-1:0] sync_q;

   // Idle rows read high, so reset to all-ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, press/release debounce, key code output.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DWELL      = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic              ani_clk,
   input  logic              reset,
   input  logic [ROWS-1:0]   key_row,
   output logic [COLS-1:0]   key_col,
   output logic [CODE_W-1:0] value,
   output logic              key_valid,
   output logic              key_down
);

   // Dwell shorter than the synchroniser plus settle time would sample a stale column.
   localparam int unsigned DWELL_EFF = (SCAN_DWELL < SCAN_DWELL_MIN) ? SCAN_DWELL_MIN : SCAN_DWELL;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_EFF - 1);
   localparam logic [CNT_W-1:0] DB_TARGET  = CNT_W'(DEBOUNCE_CYCLES);

   logic [ROWS-1:0]   row_s;

   state_e            state_q,     state_d;
   logic [IDX_W-1:0]  col_q,       col_d;
   logic [CNT_W-1:0]  dwell_q,     dwell_d;
   logic [CNT_W-1:0]  db_cnt_q,    db_cnt_d;
   logic [CNT_W-1:0]  rel_cnt_q,   rel_cnt_d;
   logic [ROWS-1:0]   pat_q,       pat_d;
   logic [IDX_W-1:0]  ridx_q,      ridx_d;
   logic [CODE_W-1:0] value_q,     value_d;
   logic              key_valid_q, key_valid_d;
   logic              key_down_q,  key_down_d;
   logic [COLS-1:0]   key_col_q,   key_col_d;

   row_hit_t          hit;
   logic [CNT_W-1:0]  db_next;
   logic [CNT_W-1:0]  rel_next;

   row_sync u_row_sync (
      .clk_i (ani_clk),
      .rst_i (reset),
      .d_i   (key_row),
      .q_o   (row_s)
   );

   // State, counters and registered outputs.
   always_ff @(posedge ani_clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN;
         col_q       <= '0;
         dwell_q     <= '0;
         db_cnt_q    <= '0;
         rel_cnt_q   <= '0;
         pat_q       <= '1;
         ridx_q      <= '0;
         value_q     <= '0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         key_col_q   <= 4'b1110;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         dwell_q     <= dwell_d;
         db_cnt_q    <= db_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         pat_q       <= pat_d;
         ridx_q      <= ridx_d;
         value_q     <= value_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
         key_col_q   <= key_col_d;
      end
   end

   // Scan / debounce / hold sequencing and next-state of every register.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      dwell_d     = dwell_q;
      db_cnt_d    = db_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      pat_d       = pat_q;
      ridx_d      = ridx_q;
      value_d     = value_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      hit         = one_low(row_s);
      db_next     = db_cnt_q + CNT_W'(1);
      rel_next    = rel_cnt_q + CNT_W'(1);

      unique case (state_q)
         SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (hit.valid) begin
                  pat_d    = row_s;
                  ridx_d   = hit.idx;
                  db_cnt_d = CNT_W'(1);
                  state_d  = DEBOUNCE;
               end else begin
                  col_d = col_q + IDX_W'(1);
               end
            end else begin
               dwell_d = dwell_q + CNT_W'(1);
            end
         end

         DEBOUNCE: begin
            if (row_s != pat_q) begin
               state_d  = SCAN;
               col_d    = col_q + IDX_W'(1);
               dwell_d  = '0;
               db_cnt_d = '0;
            end else if (db_next == DB_TARGET) begin
               db_cnt_d    = db_next;
               rel_cnt_d   = '0;
               value_d     = KEY_CODE[{ridx_q, col_q}];
               key_valid_d = 1'b1;
               key_down_d  = 1'b1;
               state_d     = HELD;
            end else begin
               db_cnt_d = db_next;
            end
         end

         HELD: begin
            if (row_s == {ROWS{1'b1}}) begin
               if (rel_next == DB_TARGET) begin
                  rel_cnt_d  = '0;
                  db_cnt_d   = '0;
                  key_down_d = 1'b0;
                  col_d      = '0;
                  dwell_d    = '0;
                  state_d    = SCAN;
               end else begin
                  rel_cnt_d = rel_next;
               end
            end else begin
               rel_cnt_d = '0;
            end
         end

         default: begin
            state_d = SCAN;
            col_d   = '0;
            dwell_d = '0;
         end
      endcase

      key_col_d = ~(COLS'(1) << col_d);
   end

   assign key_col   = key_col_q;
   assign value     = value_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad, debounces one key at a time and delivers its 4-bit key code to the dot-matrix display stage that sits directly downstream. Drives one keypad column low at a time, samples the synchronised row lines and accepts a key only after it has been stable for a programmable number of samples. Issues a single-cycle strobe per accepted press and holds the code until the next accepted press.

## Interface
- SCAN_DWELL, 4: cycles each column stays driven in SCAN; the row sample is taken on the last dwell cycle; legal range 4..255.
- DEBOUNCE_CYCLES, 4: consecutive identical samples needed to accept a press or a release; legal range 2..255.
- ani_clk  in  1  single clock; everything is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- key_row  in  4  keypad row lines, active-low, asynchronous to ani_clk.
- key_col  out  4  column drive, one-hot active-low; bit c low = column c driven.
- value  out  4  code of the last accepted key; feeds the display stage.
- key_valid  out  1  one-cycle strobe, high in the cycle value takes a new code.
- key_down  out  1  high from acceptance until release is debounced.

## Operation
- key_row passes through a 2-flop synchroniser (row_s) before any use.
- Key code at (row r, column c):
  - r0 = f,e,d,c
  - r1 = b,3,6,9
  - r2 = a,2,5,8
  - r3 = 0,1,4,7
  - Columns listed in order c0..c3.
- Valid sample: exactly one row_s bit low. Zero or two-plus bits low counts as no key (ghosting rejected).
- Reset values: state SCAN, col 0, key_col=4'b1110, value=4'h0, key_valid=0, key_down=0, all counters 0.
- SCAN:
  - Drive column col for SCAN_DWELL cycles, then sample on the last dwell cycle.
  - Valid sample -> capture the row pattern, set the debounce count to 1 and go to DEBOUNCE with col unchanged.
  - Otherwise col wraps 3 -> 0 and the dwell restarts.
- DEBOUNCE:
  - Column held; row_s is sampled every cycle.
  - A sample equal to the captured pattern increments the count.
  - Any mismatch -> SCAN at the next column.
  - Count reaches DEBOUNCE_CYCLES -> value <= code, key_valid=1 for one cycle, key_down=1, go to HELD.
- HELD:
  - Column held; row_s is sampled every cycle.
  - An all-high sample increments the release count; any low bit clears it to 0.
  - Release count reaches DEBOUNCE_CYCLES -> key_down=0, go to SCAN at col 0.
  - Presses on other keys are ignored while in HELD.
- value never changes except on a key_valid cycle.
- Counters are 8-bit and saturate at their targets; they never wrap.

## Timing
- Synchroniser latency: 2 cycles from a key_row change to row_s.
- Idle scan period: 4*SCAN_DWELL cycles (16 at defaults).
- Acceptance latency:
  - Let the SCAN sample that first finds the key be at cycle t.
  - Matching samples at t+1 .. t+DEBOUNCE_CYCLES-1.
  - key_valid and the new value appear at t+DEBOUNCE_CYCLES (t+4 at defaults).
- Release latency: key_down falls DEBOUNCE_CYCLES cycles after the first all-high row_s sample of an unbroken run.
- Same-key repeat: requires a full release, then a new SCAN pass; key_valid never fires twice without an intervening key_down low.
- Press arriving mid-dwell on the driven column: first seen at that column's end-of-dwell sample.
- Reset asserted mid-DEBOUNCE or mid-HELD: outputs take their reset values asynchronously, and no strobe is generated. After deassertion, scanning restarts at col 0 on the next edge.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD)
  - the 16-entry row/column-to-code constant
  - a one_low(row) helper returning valid plus row index
  - SCAN_DWELL_MIN=4
- Sub-module row_sync: 4-bit 2-flop synchroniser with asynchronous reset to 4'b1111.
- Remainder of the block: one FSM plus the col, dwell, debounce and release counters.

## Test plan
- Reset: key_row=4'hF -> key_col cycles 1110,1101,1011,0111 every 4 cycles; value=0, key_valid=0, key_down=0.
- Key r1,c2 held 40 cycles, then released -> one key_valid pulse with value=4'h6 at sample+4; key_down high until 4 cycles after row_s goes all-high.
- Bounce: r2,c0 toggling every 2 cycles for 20 cycles, then stable -> no key_valid during bounce; single strobe with value=4'hA after the stable run.
- Ghost: rows r0 and r3 low on c3 -> no key_valid; value keeps its previous code.
- Hold r0,c0 (f), press r3,c1 (1) meanwhile, release f while 1 is still held -> strobe f only; 1 is not accepted until f's release debounces and the next scan passes c1.
- Reset pulse at DEBOUNCE count 3 for key 4 -> outputs zero immediately, no strobe; after release of reset with key still held, strobe value=4'h4 on the re-scan.
